// File: rtl/axis_video_pkg.sv
// Shared types for the AXI4-Stream video frame checker.
// Holds the checker state encoding and the tuser SOF bit position.
package axis_video_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF,
        IN_FRAME,
        RESYNC
    } state_t;

    localparam int SOF_BIT = 0;

endpackage

// File: rtl/axis_video_frame_sum.sv
// Per-frame pixel sum: accumulates counted pixels, latches on done.
// Ports: clk, nrst, pixel/first/done strobes, data in, checksum out.
import axis_video_pkg::*;

module axis_video_frame_sum #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  pixel,
    input  logic                  first,
    input  logic                  done,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [31:0]           checksum
);

    logic [31:0] acc;
    logic [31:0] sum_next;

    always_comb begin
        sum_next = (first ? 32'd0 : acc) + 32'(data);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc      <= '0;
            checksum <= '0;
        end else begin
            if (pixel)
                acc <= sum_next;
            // a frame can also close on a discarded resync beat
            if (done)
                checksum <= pixel ? sum_next : acc;
        end
    end

endmodule

// File: rtl/axis_video_frame_check.sv
// AXI4-Stream video frame structure checker with SOF/EOL error flags.
// Ports: s_axis_* sink, enable, err_clr, frame_done/frame_cnt, err_*,
// pix_x/pix_y; checksum only with AXIS_VIDEO_FRAME_CHECK_CHECKSUM_EN.
import axis_video_pkg::*;

module axis_video_frame_check #(
    parameter int DATA_WIDTH   = 8,
    parameter int USER_WIDTH   = 10,
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 768
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_arstn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  enable,
    input  logic                  err_clr,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic                  err_sof,
    output logic                  err_eol_early,
    output logic                  err_eol_late,
`ifdef AXIS_VIDEO_FRAME_CHECK_CHECKSUM_EN
    output logic [31:0]           checksum,
`endif
    output logic [15:0]           pix_x,
    output logic [15:0]           pix_y
);

    localparam logic [15:0] X_LAST = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(IMAGE_HEIGHT - 1);

    state_t      state;
    logic        beat;
    logic        sof;
    logic        restart;
    logic        pixel;
    logic        first;
    logic [15:0] ex;
    logic [15:0] ey;
    logic        eol_pix;
    logic        rs_eol;
    logic        eol;
    logic [15:0] eol_y;
    logic        done;
    logic        early;
    logic        late;
    logic        unused_bits;

    assign unused_bits = ^{s_axis_tuser, s_axis_tdata};

    always_comb begin
        beat    = s_axis_tvalid & s_axis_tready;
        sof     = s_axis_tuser[SOF_BIT];
        restart = beat & sof & (state != WAIT_SOF)
                & !(state == IN_FRAME && pix_x == '0 && pix_y == '0);
        pixel   = beat & ((state == WAIT_SOF && sof)
                | state == IN_FRAME | restart);
        // every counted SOF beat is pixel (0,0)
        first   = pixel & sof;
        ex      = first ? 16'd0 : pix_x;
        ey      = first ? 16'd0 : pix_y;
        eol_pix = pixel & s_axis_tlast;
        early   = eol_pix & (ex != X_LAST);
        late    = pixel & !s_axis_tlast & (ex == X_LAST);
        rs_eol  = beat & (state == RESYNC) & !sof & s_axis_tlast;
        eol     = eol_pix | rs_eol;
        eol_y   = eol_pix ? ey : pix_y;
        done    = eol & (eol_y == Y_LAST);
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
        if (!s_axis_arstn) begin
            state         <= WAIT_SOF;
            s_axis_tready <= 1'b0;
            frame_done    <= 1'b0;
            frame_cnt     <= '0;
            err_sof       <= 1'b0;
            err_eol_early <= 1'b0;
            err_eol_late  <= 1'b0;
            pix_x         <= '0;
            pix_y         <= '0;
        end else begin
            s_axis_tready <= enable;
            frame_done    <= done;
            // a new error wins over a simultaneous clear
            err_sof       <= (err_sof & !err_clr) | restart;
            err_eol_early <= (err_eol_early & !err_clr) | early;
            err_eol_late  <= (err_eol_late & !err_clr) | late;
            if (done) begin
                frame_cnt <= frame_cnt + 16'd1;
                state     <= WAIT_SOF;
                pix_x     <= '0;
                pix_y     <= '0;
            end else if (eol) begin
                state <= IN_FRAME;
                pix_x <= '0;
                pix_y <= eol_y + 16'd1;
            end else if (late) begin
                state <= RESYNC;
                pix_x <= ex;
                pix_y <= ey;
            end else if (pixel) begin
                state <= IN_FRAME;
                pix_x <= ex + 16'd1;
                pix_y <= ey;
            end
        end
    end

`ifdef AXIS_VIDEO_FRAME_CHECK_CHECKSUM_EN
    axis_video_frame_sum #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sum (
        .clk     (s_axis_aclk),
        .nrst    (s_axis_arstn),
        .pixel   (pixel),
        .first   (first),
        .done    (done),
        .data    (s_axis_tdata),
        .checksum(checksum)
    );
`endif

endmodule
